ex_mem_pipe_reg: RTL and testbench
==================================

Name: ex_mem_pipe_reg

Overview:
Parametrised, elastic EX/MEM pipeline register for the RV32 core. It replaces the fixed-width, always-advancing stage register with a valid/ready handshake, synchronous flush, and an optional skid buffer. Bubbles always carry zero control bits. It also exports a forwarding tap and a saturating stall counter for the hazard unit and debug.
The block sits between the ALU/EX stage and the data-memory/IO stage.

Parameters:
XLEN, 32, width of ALU result and store data
RD_W, 5, destination register index width
CTRL_W, 6, control bundle width; layout fixed in ex_mem_pkg
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, stall counter width

Ports:
clk  in  1  pipeline clock, all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  EX has a valid instruction
in_ready  out  1  stage can accept this cycle
in_ctrl  in  CTRL_W  {RegWrite,MemRead,MemWrite,MemOrIoToReg,IoRead,IoWrite}
in_alu  in  XLEN  ALU result / address
in_rs2  in  XLEN  store data
in_rd  in  RD_W  destination register
in_bw  in  2  byte/half/word select
flush  in  1  kill contents of this stage and the incoming instruction
out_valid  out  1  MEM-side payload valid
out_ready  in  1  MEM stage accepts this cycle
out_ctrl  out  CTRL_W  registered control; all-zero when out_valid=0
out_alu  out  XLEN  registered ALU result
out_rs2  out  XLEN  registered store data
out_rd  out  RD_W  registered rd
out_bw  out  2  registered byte/word select
fwd_valid  out  1  out_valid & RegWrite & (out_rd != 0)
fwd_rd  out  RD_W  equals out_rd
fwd_data  out  XLEN  equals out_alu
stall_cnt  out  CNT_W  cycles with out_valid & !out_ready; saturates

Behaviour:
- Reset (rst_n=0, async): out_valid=0; out_ctrl, out_alu, out_rs2, out_rd, out_bw = 0; skid entry empty; stall_cnt=0; in_ready=1 (SKID=1 register).
- Handshake and latency:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - Accepted data appears on out_* at the next posedge, so latency is 1 cycle.
- SKID=0:
  - in_ready = out_ready | !out_valid, combinational.
  - The main register loads on an input transfer.
  - out_valid clears when an output transfer occurs with no input transfer.
- SKID=1: the main register holds the head, and the skid register holds one overflow entry.
  - in_ready is registered and equals !skid_full.
  - Input accepted while main is full and out_ready=0 goes into the skid register.
  - On an output transfer, skid contents (if any) move to main in the same edge. A simultaneous input then goes to skid if main is refilled from skid, otherwise to main.
  - Entries emerge in order; none are lost or duplicated. Full throughput is 1 per cycle while out_ready=1.
- flush (synchronous, highest priority):
  - Next edge: out_valid=0, skid empty, out_ctrl=0, in_ready=1.
  - An input transfer in the flush cycle is discarded.
  - Payload fields other than ctrl may retain stale values.
- Bubble rule: whenever out_valid=0, out_ctrl=0, so MEM and IO side effects are impossible.
- Forwarding is purely combinational from the registered outputs; there is no extra latency.
- stall_cnt:
  - Increments on each cycle with out_valid & !out_ready.
  - Holds at 2^CNT_W-1 once saturated.
  - Cleared only by reset; flush does not clear it.
- Reset asserted mid-transfer: all state is dropped immediately, with no partial update on the next edge.

Decomposition:
- ex_mem_pkg holds:
  - CTRL_W and bit index constants CTRL_REGWRITE=5 … CTRL_IOWRITE=0
  - BW_BYTE=2'b00, BW_HALF=2'b01, BW_WORD=2'b10
  - a packed struct ex_mem_payload_t {ctrl, alu, rs2, rd, bw}
- One natural sub-module: pipe_skid_buf, a generic two-entry elastic buffer over a WIDTH-bit payload.
  - Instantiated when SKID=1.
  - ex_mem_pipe_reg wraps it and adds the bubble gating, forwarding tap and stall counter.

Test Plan:
- Reset then stream 4 instrs (alu=0x10,0x20,0x30,0x40, rd=1..4, out_ready=1) -> out_valid on cycles 1..4, same order, in_ready stays 1.
- SKID=1, out_ready=0 for 3 cycles while feeding alu=0xA,0xB,0xC -> 0xA held in main, 0xB in skid, in_ready=0 from cycle 2, 0xC held by source. Release -> 0xA,0xB,0xC in order, stall_cnt=2 or 3 per stall cycles counted.
- flush in the same cycle as in_valid with ctrl=6'b100000 -> next cycle out_valid=0, out_ctrl=0, fwd_valid=0, in_ready=1.
- Instr rd=0, RegWrite=1 -> fwd_valid=0. Instr rd=7, RegWrite=1, alu=0xDEADBEEF -> fwd_valid=1, fwd_rd=7, fwd_data=0xDEADBEEF.
- CNT_W=4, hold out_ready=0 with valid for 20 cycles -> stall_cnt saturates at 15.
- Assert rst_n=0 between edges while skid is full -> outputs zero immediately, in_ready=1 after release.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// EX/MEM stage shared definitions: control bundle layout,
// byte-width selects and the default-width payload record.
package ex_mem_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RD_W_DEF = 5;
    localparam int CTRL_W   = 6;

    localparam int CTRL_REGWRITE = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_IOREAD   = 1;
    localparam int CTRL_IOWRITE  = 0;

    localparam logic [1:0] BW_BYTE = 2'b00;
    localparam logic [1:0] BW_HALF = 2'b01;
    localparam logic [1:0] BW_WORD = 2'b10;

    typedef struct packed {
        logic [CTRL_W-1:0]   ctrl;
        logic [XLEN_DEF-1:0] alu;
        logic [XLEN_DEF-1:0] rs2;
        logic [RD_W_DEF-1:0] rd;
        logic [1:0]          bw;
    } ex_mem_payload_t;

    function automatic logic [CTRL_W-1:0] gate_ctrl(
        input logic              v,
        input logic [CTRL_W-1:0] c
    );
        return v ? c : '0;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry elastic buffer: head register plus one overflow
// slot, with ready registered off the overflow occupancy.
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer  = in_valid_i & ~skid_v_q;
    assign out_xfer = main_v_q & out_ready_i;

    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush_i) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (out_xfer) begin
            // ready is low while skid holds data, so no input here
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = in_xfer;
                if (in_xfer) begin
                    main_d = in_data_i;
                end
            end
        end else if (in_xfer) begin
            if (main_v_q) begin
                skid_d   = in_data_i;
                skid_v_d = 1'b1;
            end else begin
                main_d   = in_data_i;
                main_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign in_ready_o  = ~skid_v_q;
    assign out_valid_o = main_v_q;
    assign out_data_o  = main_q;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// Elastic EX/MEM register with flush, bubble ctrl gating,
// a forwarding tap and a saturating stall counter.
module ex_mem_pipe_reg #(
    parameter int XLEN   = 32,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 6,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [1:0]        in_bw,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [XLEN-1:0]   out_alu,
    output logic [XLEN-1:0]   out_rs2,
    output logic [RD_W-1:0]   out_rd,
    output logic [1:0]        out_bw,
    output logic              fwd_valid,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic [CNT_W-1:0]  stall_cnt
);
    import ex_mem_pkg::*;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   rs2;
        logic [RD_W-1:0]   rd;
        logic [1:0]        bw;
    } pl_t;

    localparam int PW = $bits(pl_t);

    pl_t              in_pl;
    pl_t              head;
    logic [PW-1:0]    head_raw;
    logic             head_v;
    logic [CNT_W-1:0] stall_q, stall_d;

    assign in_pl.ctrl = in_ctrl;
    assign in_pl.alu  = in_alu;
    assign in_pl.rs2  = in_rs2;
    assign in_pl.rd   = in_rd;
    assign in_pl.bw   = in_bw;

    if (SKID != 0) begin : g_skid
        pipe_skid_buf #(
            .WIDTH(PW)
        ) u_buf (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .flush_i    (flush),
            .in_valid_i (in_valid),
            .in_ready_o (in_ready),
            .in_data_i  (in_pl),
            .out_valid_o(head_v),
            .out_ready_i(out_ready),
            .out_data_o (head_raw)
        );
    end else begin : g_single
        pl_t  main_q, main_d;
        logic v_q, v_d;
        logic in_xfer;

        // combinational ready: accept when head drains or is empty
        assign in_ready = out_ready | ~v_q;
        assign in_xfer  = in_valid & in_ready;

        always_comb begin
            main_d = main_q;
            v_d    = v_q;
            if (flush) begin
                v_d = 1'b0;
            end else if (in_xfer) begin
                main_d = in_pl;
                v_d    = 1'b1;
            end else if (v_q & out_ready) begin
                v_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_q <= '0;
                v_q    <= 1'b0;
            end else begin
                main_q <= main_d;
                v_q    <= v_d;
            end
        end

        assign head_v   = v_q;
        assign head_raw = main_q;
    end

    assign head = pl_t'(head_raw);

    always_comb begin
        stall_d = stall_q;
        if (head_v && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    // bubbles never carry control bits
    assign out_valid = head_v;
    assign out_ctrl  = head_v ? head.ctrl : '0;
    assign out_alu   = head.alu;
    assign out_rs2   = head.rs2;
    assign out_rd    = head.rd;
    assign out_bw    = head.bw;
    assign stall_cnt = stall_q;

    assign fwd_valid = head_v & out_ctrl[CTRL_REGWRITE] & (head.rd != '0);
    assign fwd_rd    = head.rd;
    assign fwd_data  = head.alu;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Randomised bench for ex_mem_pipe_reg against a queue-based
// two-slot FIFO model with a saturating stall count.
module tb_ex_mem_pipe_reg;
    import ex_mem_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_ctrl;
    logic [31:0]   in_alu;
    logic [31:0]   in_rs2;
    logic [4:0]    in_rd;
    logic [1:0]    in_bw;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    out_ctrl;
    logic [31:0]   out_alu;
    logic [31:0]   out_rs2;
    logic [4:0]    out_rd;
    logic [1:0]    out_bw;
    logic          fwd_valid;
    logic [4:0]    fwd_rd;
    logic [31:0]   fwd_data;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    ex_mem_payload_t mq[$];
    int              m_stall = 0;

    ex_mem_pipe_reg #(
        .XLEN(32), .RD_W(5), .CTRL_W(6), .SKID(1), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_alu(in_alu), .in_rs2(in_rs2),
        .in_rd(in_rd), .in_bw(in_bw), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_alu(out_alu), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_bw(out_bw),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        ex_mem_payload_t h;
        check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        if (mq.size() > 0) begin
            h = mq[0];
            check("out_ctrl", 64'(out_ctrl), 64'(h.ctrl));
            check("out_alu", 64'(out_alu), 64'(h.alu));
            check("out_rs2", 64'(out_rs2), 64'(h.rs2));
            check("out_rd", 64'(out_rd), 64'(h.rd));
            check("out_bw", 64'(out_bw), 64'(h.bw));
            check("fwd_valid", 64'(fwd_valid),
                  64'(h.ctrl[5] && (h.rd != 0)));
            check("fwd_rd", 64'(fwd_rd), 64'(h.rd));
            check("fwd_data", 64'(fwd_data), 64'(h.alu));
        end else begin
            check("bubble_ctrl", 64'(out_ctrl), 64'd0);
            check("bubble_fwd", 64'(fwd_valid), 64'd0);
        end
    endtask

    // called at a negedge; returns at the following negedge
    task automatic cyc(input bit iv, input bit ordy, input bit fl,
                       input logic [5:0] c, input logic [31:0] a,
                       input logic [31:0] s, input logic [4:0] d,
                       input logic [1:0] b);
        ex_mem_payload_t p;
        bit ov, ir;
        check_model();
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_ctrl   = c;
        in_alu    = a;
        in_rs2    = s;
        in_rd     = d;
        in_bw     = b;
        @(posedge clk);
        ov = mq.size() > 0;
        ir = mq.size() < 2;
        p.ctrl = c; p.alu = a; p.rs2 = s; p.rd = d; p.bw = b;
        if (ov && !ordy && m_stall < (1 << CW) - 1) m_stall++;
        if (fl) begin
            mq.delete();
        end else begin
            if (ov && ordy) void'(mq.pop_front());
            if (iv && ir) mq.push_back(p);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; out_ready = 0; flush = 0;
        in_ctrl = 0; in_alu = 0; in_rs2 = 0; in_rd = 0; in_bw = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_ctrl"}, 64'(out_ctrl), 64'd0);
        check({tag, "_alu"}, 64'(out_alu), 64'd0);
        check({tag, "_rs2"}, 64'(out_rs2), 64'd0);
        check({tag, "_rd"}, 64'(out_rd), 64'd0);
        check({tag, "_bw"}, 64'(out_bw), 64'd0);
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        check({tag, "_stall"}, 64'(stall_cnt), 64'd0);
    endtask

    initial begin
        rst_n = 0;
        idle();
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst_n = 1;

        // back-to-back stream, MEM always ready
        for (int i = 1; i <= 4; i++)
            cyc(1, 1, 0, 6'b100000, 32'(i * 16), 32'(i), 5'(i), BW_WORD);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);

        // back-pressure fills head and skid, third held by source
        cyc(1, 0, 0, 6'b001000, 32'hA, 1, 1, BW_BYTE);
        cyc(1, 0, 0, 6'b001000, 32'hB, 2, 2, BW_HALF);
        cyc(1, 0, 0, 6'b001000, 32'hC, 3, 3, BW_WORD);
        check("skid_full_rdy", 64'(in_ready), 64'd0);
        check("skid_head", 64'(out_alu), 64'hA);
        cyc(1, 1, 0, 6'b001000, 32'hC, 3, 3, BW_WORD);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);

        // flush kills the incoming instruction
        cyc(1, 1, 1, 6'b100000, 32'h55, 0, 3, BW_WORD);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ctrl", 64'(out_ctrl), 64'd0);

        // forwarding tap
        cyc(1, 1, 0, 6'b100000, 32'h1234, 0, 0, BW_WORD);
        check("fwd_rd0", 64'(fwd_valid), 64'd0);
        cyc(1, 1, 0, 6'b100000, 32'hDEADBEEF, 0, 7, BW_WORD);
        check("fwd_rd7_v", 64'(fwd_valid), 64'd1);
        check("fwd_rd7_d", 64'(fwd_data), 64'hDEADBEEF);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);

        // long stall saturates the counter
        for (int i = 0; i < 20; i++)
            cyc(1, 0, 0, 6'b000100, 32'(i), 0, 2, BW_BYTE);
        check("stall_sat", 64'(stall_cnt), 64'd15);

        // async reset between edges with skid full
        #3 rst_n = 0;
        #1 check_zero("arst");
        mq.delete();
        m_stall = 0;
        idle();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 400; i++) begin
            logic [4:0] d;
            d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                $urandom_range(0, 24) == 0, 6'($urandom), $urandom,
                $urandom, d, 2'($urandom_range(0, 2)));
            if (i == 200) begin
                #3 rst_n = 0;
                #1 check_zero("rrst");
                mq.delete();
                m_stall = 0;
                @(negedge clk);
                rst_n = 1;
            end
        end
        check_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
